if_pc_stage: RTL and testbench

//  Program-counter register and IF/ID pipeline latch of the instruction-fetch stage.
//  - Consumes the next-PC value chosen by the fetch-stage 2:1 next-PC mux.
//  - Drives the instruction-memory address and returns PC+step as that mux's sequential input.
//  - Captures fetched instructions into the IF/ID latch, with stall, flush and halt control.

---
 rtl/if_pc_stage.sv | 111 +++++++++++
 tb/tb_if_pc_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: program counter and IF/ID pipeline latch.
// Handles stall, flush and a one-way halt on a reserved instruction encoding.
module if_pc_stage #(
   parameter int unsigned                bus_size   = 10,
   parameter int unsigned                inst_size  = 32,
   parameter logic [bus_size-1:0]        RESET_PC   = '0,
   parameter int unsigned                PC_STEP    = 1,
   parameter logic [inst_size-1:0]       HALT_INSTR = inst_size'(32'hFFFF_FFFF),
   parameter int unsigned                CNT_SIZE   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [bus_size-1:0]  next_pc_in,
   input  logic [inst_size-1:0] instr_in,
   input  logic                 stall,
   input  logic                 flush,
   output logic [bus_size-1:0]  pc_out,
   output logic [bus_size-1:0]  pc_plus_out,
   output logic [bus_size-1:0]  if_id_pc,
   output logic [bus_size-1:0]  if_id_pc_plus,
   output logic [inst_size-1:0] if_id_instr,
   output logic                 if_id_valid,
   output logic                 halted,
   output logic [CNT_SIZE-1:0]  fetch_count
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [bus_size-1:0]  pc_q, pc_d;
   logic [bus_size-1:0]  if_id_pc_q, if_id_pc_d;
   logic [bus_size-1:0]  if_id_pc_plus_q, if_id_pc_plus_d;
   logic [inst_size-1:0] if_id_instr_q, if_id_instr_d;
   logic                 if_id_valid_q, if_id_valid_d;
   logic [CNT_SIZE-1:0]  fetch_count_q, fetch_count_d;
   logic [bus_size-1:0]  pc_plus;

   // Sequential fetch address; wraps modulo the address space.
   assign pc_plus = pc_q + bus_size'(PC_STEP);

   // Next-state logic: in RUN, flush beats stall beats advance.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      if_id_pc_d      = if_id_pc_q;
      if_id_pc_plus_d = if_id_pc_plus_q;
      if_id_instr_d   = if_id_instr_q;
      if_id_valid_d   = if_id_valid_q;
      fetch_count_d   = fetch_count_q;
      case (state_q)
         RUN: begin
            if (flush) begin
               pc_d          = next_pc_in;
               if_id_instr_d = '0;
               if_id_valid_d = 1'b0;
            end else if (!stall) begin
               if_id_pc_d      = pc_q;
               if_id_pc_plus_d = pc_plus;
               if_id_instr_d   = instr_in;
               if_id_valid_d   = 1'b1;
               if (fetch_count_q != '1) begin
                  fetch_count_d = fetch_count_q + CNT_SIZE'(1);
               end
               if (instr_in == HALT_INSTR) begin
                  state_d = HALT;
               end else begin
                  pc_d = next_pc_in;
               end
            end
         end
         HALT: begin
            // Halt instruction drains downstream once, then only bubbles.
            if (!stall) begin
               if_id_instr_d = '0;
               if_id_valid_d = 1'b0;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= RUN;
         pc_q            <= RESET_PC;
         if_id_pc_q      <= '0;
         if_id_pc_plus_q <= '0;
         if_id_instr_q   <= '0;
         if_id_valid_q   <= 1'b0;
         fetch_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         if_id_pc_q      <= if_id_pc_d;
         if_id_pc_plus_q <= if_id_pc_plus_d;
         if_id_instr_q   <= if_id_instr_d;
         if_id_valid_q   <= if_id_valid_d;
         fetch_count_q   <= fetch_count_d;
      end
   end

   assign pc_out        = pc_q;
   assign pc_plus_out   = pc_plus;
   assign if_id_pc      = if_id_pc_q;
   assign if_id_pc_plus = if_id_pc_plus_q;
   assign if_id_instr   = if_id_instr_q;
   assign if_id_valid   = if_id_valid_q;
   assign halted        = (state_q == HALT);
   assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed bench for if_pc_stage: sequential fetch, stall, flush, PC wrap,
// halt and reset-while-halted, against hand-computed values.
module tb_if_pc_stage;

   logic        clk;
   logic        reset;
   logic [9:0]  next_pc_in;
   logic [31:0] instr_in;
   logic        stall;
   logic        flush;
   logic [9:0]  pc_out;
   logic [9:0]  pc_plus_out;
   logic [9:0]  if_id_pc;
   logic [9:0]  if_id_pc_plus;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_count;

   logic        seq;
   logic [9:0]  next_pc_force;
   logic [31:0] mem [1024];

   int total = 0;
   int bad   = 0;

   if_pc_stage dut (
      .clk           (clk),
      .reset         (reset),
      .next_pc_in    (next_pc_in),
      .instr_in      (instr_in),
      .stall         (stall),
      .flush         (flush),
      .pc_out        (pc_out),
      .pc_plus_out   (pc_plus_out),
      .if_id_pc      (if_id_pc),
      .if_id_pc_plus (if_id_pc_plus),
      .if_id_instr   (if_id_instr),
      .if_id_valid   (if_id_valid),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   // Instruction memory model and fetch-stage next-PC mux.
   assign instr_in   = mem[pc_out];
   assign next_pc_in = seq ? pc_plus_out : next_pc_force;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[7] = 32'hFFFF_FFFF;

      // Test 1: reset then sequential fetch
      reset = 1'b1; stall = 1'b0; flush = 1'b0; seq = 1'b1; next_pc_force = 10'h000;
      step(); step();
      check("rst_pc",      64'(pc_out),      64'h0);
      check("rst_pcplus",  64'(pc_plus_out), 64'h1);
      check("rst_valid",   64'(if_id_valid), 64'h0);
      check("rst_instr",   64'(if_id_instr), 64'h0);
      check("rst_halted",  64'(halted),      64'h0);
      check("rst_count",   64'(fetch_count), 64'h0);
      reset = 1'b0;
      step();
      check("s1_pc",       64'(pc_out),      64'h1);
      check("s1_instr",    64'(if_id_instr), 64'h1000_0000);
      check("s1_valid",    64'(if_id_valid), 64'h1);
      check("s1_count",    64'(fetch_count), 64'h1);
      step();
      check("s2_pc",       64'(pc_out),        64'h2);
      check("s2_ifpc",     64'(if_id_pc),      64'h1);
      check("s2_ifpcplus", 64'(if_id_pc_plus), 64'h2);
      check("s2_count",    64'(fetch_count),   64'h2);
      step();
      check("s3_pc",       64'(pc_out),      64'h3);
      step(); step();
      check("s5_pc",       64'(pc_out),      64'h5);
      check("s5_instr",    64'(if_id_instr), 64'h1000_0004);
      check("s5_count",    64'(fetch_count), 64'h5);

      // Test 2: stall three cycles at pc 5
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_pc",    64'(pc_out),      64'h5);
         check("stall_instr", 64'(if_id_instr), 64'h1000_0004);
         check("stall_ifpc",  64'(if_id_pc),    64'h4);
         check("stall_count", 64'(fetch_count), 64'h5);
      end
      stall = 1'b0;
      step();
      check("resume_pc",    64'(pc_out),      64'h6);
      check("resume_instr", 64'(if_id_instr), 64'h1000_0005);
      check("resume_count", 64'(fetch_count), 64'h6);

      // Test 3: flush wins over stall
      stall = 1'b1; flush = 1'b1; seq = 1'b0; next_pc_force = 10'h040;
      step();
      check("flush_pc",    64'(pc_out),      64'h040);
      check("flush_valid", 64'(if_id_valid), 64'h0);
      check("flush_instr", 64'(if_id_instr), 64'h0);
      check("flush_ifpc",  64'(if_id_pc),    64'h5);
      check("flush_count", 64'(fetch_count), 64'h6);
      stall = 1'b0; flush = 1'b0; seq = 1'b1;
      step();
      check("postfl_pc",    64'(pc_out),      64'h041);
      check("postfl_instr", 64'(if_id_instr), 64'h1000_0040);
      check("postfl_ifpc",  64'(if_id_pc),    64'h040);
      check("postfl_count", 64'(fetch_count), 64'h7);

      // Test 4: PC wrap at top of address space
      flush = 1'b1; seq = 1'b0; next_pc_force = 10'h3FF;
      step();
      check("wrap_pc",     64'(pc_out),      64'h3FF);
      check("wrap_pcplus", 64'(pc_plus_out), 64'h0);
      flush = 1'b0; seq = 1'b1;
      step();
      check("wrap_next_pc", 64'(pc_out),        64'h0);
      check("wrap_ifpc",    64'(if_id_pc),      64'h3FF);
      check("wrap_ifplus",  64'(if_id_pc_plus), 64'h0);
      check("wrap_instr",   64'(if_id_instr),   64'h1000_03FF);
      check("wrap_count",   64'(fetch_count),   64'h8);

      // Test 5: halt instruction at pc 7
      flush = 1'b1; seq = 1'b0; next_pc_force = 10'h007;
      step();
      check("pre_halt_pc", 64'(pc_out), 64'h7);
      flush = 1'b0; seq = 1'b1;
      step();
      check("halt_instr",  64'(if_id_instr), 64'hFFFF_FFFF);
      check("halt_valid",  64'(if_id_valid), 64'h1);
      check("halt_flag",   64'(halted),      64'h1);
      check("halt_pc",     64'(pc_out),      64'h7);
      check("halt_count",  64'(fetch_count), 64'h9);
      step();
      check("halt2_valid", 64'(if_id_valid), 64'h0);
      check("halt2_instr", 64'(if_id_instr), 64'h0);
      check("halt2_pc",    64'(pc_out),      64'h7);
      check("halt2_count", 64'(fetch_count), 64'h9);
      flush = 1'b1; seq = 1'b0; next_pc_force = 10'h100;
      step();
      check("halt_flush_pc",   64'(pc_out), 64'h7);
      check("halt_flush_flag", 64'(halted), 64'h1);

      // Test 6: reset while halted, then normal fetch
      flush = 1'b0; reset = 1'b1;
      step();
      check("rh_pc",     64'(pc_out),      64'h0);
      check("rh_halted", 64'(halted),      64'h0);
      check("rh_count",  64'(fetch_count), 64'h0);
      check("rh_valid",  64'(if_id_valid), 64'h0);
      reset = 1'b0; seq = 1'b1;
      step();
      check("rh_run_pc",    64'(pc_out),      64'h1);
      check("rh_run_instr", 64'(if_id_instr), 64'h1000_0000);
      check("rh_run_count", 64'(fetch_count), 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
